hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It consumes the register addresses and control status the datapath exports, and drives back the stall, flush and forward-select controls. It keeps its own registered copy of the W-stage destination and M-stage result source, so it tracks the pipeline cycle by cycle. Two saturating event counters (stall cycles, control flushes) are included for performance measurement.

---
 rtl/hazard_unit_if.sv | 17 +
 rtl/hazard_unit.sv | 58 +++++
 tb/tb_hazard_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: datapath <-> hazard controller signal bundle
interface hazard_unit_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs1, Rs2, Rs1E, Rs2E, RdE, Rdm;
    logic [1:0]       ResultSrcE, PCSrcE;
    logic             RegWriteM, RegWriteW, cnt_clr;
    logic             StallF, StallD, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output Rs1, Rs2, Rs1E, Rs2E, RdE, Rdm, ResultSrcE, PCSrcE, RegWriteM, RegWriteW, cnt_clr,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );
    modport slave (
        input  Rs1, Rs2, Rs1E, Rs2E, RdE, Rdm, ResultSrcE, PCSrcE, RegWriteM, RegWriteW, cnt_clr,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the five-stage pipeline with event counters
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_unit_if.slave hz_if
);
    logic [4:0]       r_rd_w;
    logic [1:0]       r_result_src_m;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_ctl, w_lw_stall, w_stall;
    // M can only supply ALU results (00) and immediates (11); loads and links come via W
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [1:0] src_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        logic m_hit;
        m_hit = wr_m && rd_m != 5'd0 && rd_m == rs;
        return (m_hit && src_m == 2'b00) ? 2'd2 :
               (m_hit && src_m == 2'b11) ? 2'd3 :
               (wr_w && rd_w != 5'd0 && rd_w == rs) ? 2'd1 : 2'd0;
    endfunction
    always_comb begin
        w_ctl      = hz_if.PCSrcE != 2'b00;
        w_lw_stall = (hz_if.ResultSrcE == 2'b01 || hz_if.ResultSrcE == 2'b10) && hz_if.RdE != 5'd0 &&
                     (hz_if.RdE == hz_if.Rs1 || hz_if.RdE == hz_if.Rs2);
        w_stall    = !rst && w_lw_stall && !w_ctl;
    end
    assign hz_if.StallF    = w_stall;
    assign hz_if.StallD    = w_stall;
    assign hz_if.FlushD    = rst || w_ctl;
    assign hz_if.FlushE    = rst || w_lw_stall || w_ctl;
    assign hz_if.ForwardAE = rst ? 2'd0 : fwd_sel(hz_if.Rs1E, hz_if.Rdm, hz_if.RegWriteM, r_result_src_m,
                                                  r_rd_w, hz_if.RegWriteW);
    assign hz_if.ForwardBE = rst ? 2'd0 : fwd_sel(hz_if.Rs2E, hz_if.Rdm, hz_if.RegWriteM, r_result_src_m,
                                                  r_rd_w, hz_if.RegWriteW);
    assign hz_if.stall_cnt = r_stall_cnt;
    assign hz_if.flush_cnt = r_flush_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_w         <= 5'd0;
            r_result_src_m <= 2'b00;
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
        end else begin
            r_rd_w         <= hz_if.Rdm;
            r_result_src_m <= hz_if.ResultSrcE;
            if (hz_if.cnt_clr)
                r_stall_cnt <= '0;
            else if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (hz_if.cnt_clr)
                r_flush_cnt <= '0;
            else if (w_ctl && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven per-cycle vectors plus saturation/clear/reset sequences
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    hazard_unit_if #(.CNT_W(4)) hz_if ();
    hazard_unit #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .hz_if(hz_if));
    typedef struct {
        logic       rst, clr;
        logic [4:0] rs1, rs2, rs1e, rs2e, rde, rdm;
        logic [1:0] rsrce;
        logic       rwm, rww;
        logic [1:0] pcs;
        logic       sf, sd, fd, fe;
        logic [1:0] fa, fb;
        logic [3:0] sc, fc;
    } vec_t;
    vec_t vecs[$];
    task automatic drive(input vec_t v);
        rst              = v.rst;
        hz_if.cnt_clr    = v.clr;
        hz_if.Rs1        = v.rs1;
        hz_if.Rs2        = v.rs2;
        hz_if.Rs1E       = v.rs1e;
        hz_if.Rs2E       = v.rs2e;
        hz_if.RdE        = v.rde;
        hz_if.Rdm        = v.rdm;
        hz_if.ResultSrcE = v.rsrce;
        hz_if.RegWriteM  = v.rwm;
        hz_if.RegWriteW  = v.rww;
        hz_if.PCSrcE     = v.pcs;
    endtask
    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask
    task automatic chk_all(input string n, input vec_t v);
        chk({n, ".StallF"}, 16'(hz_if.StallF), 16'(v.sf));
        chk({n, ".StallD"}, 16'(hz_if.StallD), 16'(v.sd));
        chk({n, ".FlushD"}, 16'(hz_if.FlushD), 16'(v.fd));
        chk({n, ".FlushE"}, 16'(hz_if.FlushE), 16'(v.fe));
        chk({n, ".ForwardAE"}, 16'(hz_if.ForwardAE), 16'(v.fa));
        chk({n, ".ForwardBE"}, 16'(hz_if.ForwardBE), 16'(v.fb));
        chk({n, ".stall_cnt"}, 16'(hz_if.stall_cnt), 16'(v.sc));
        chk({n, ".flush_cnt"}, 16'(hz_if.flush_cnt), 16'(v.fc));
    endtask
    initial begin
        vec_t s;
        //            rst clr rs1 rs2 rs1e rs2e rde rdm src rwm rww pcs | sf sd fd fe fa fb sc fc
        vecs.push_back('{1, 0, 0, 0, 5, 0, 0, 5, 0, 1, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0}); // in reset
        vecs.push_back('{0, 0, 0, 0, 5, 0, 0, 5, 0, 1, 1, 0,  0, 0, 0, 0, 2, 0, 0, 0}); // M fwd, RdW=0
        vecs.push_back('{0, 0, 0, 0, 5, 5, 7, 0, 3, 1, 1, 0,  0, 0, 0, 0, 1, 1, 0, 0}); // W fwd, lui in E
        vecs.push_back('{0, 0, 0, 0, 0, 7, 0, 7, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0}); // lui fwd from M
        vecs.push_back('{0, 0, 1, 3, 7, 0, 3, 0, 1, 0, 1, 0,  1, 1, 0, 1, 1, 0, 0, 0}); // load-use stall
        vecs.push_back('{0, 0, 0, 0, 3, 3, 0, 3, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0}); // load in M: no fwd
        vecs.push_back('{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1, 0}); // load in W: fwd 1
        vecs.push_back('{0, 0, 4, 0, 0, 0, 4, 0, 1, 0, 0, 1,  0, 0, 1, 1, 0, 0, 1, 0}); // ctl beats lwStall
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1}); // rd=0 never matches
        vecs.push_back('{0, 0, 0, 9, 0, 0, 9, 9, 2, 1, 0, 0,  1, 1, 0, 1, 0, 0, 1, 1}); // jal link stall
        vecs.push_back('{0, 0, 0, 0, 9, 9, 0, 9, 0, 1, 1, 0,  0, 0, 0, 0, 1, 1, 2, 1}); // M=10 falls to W
        vecs.push_back('{0, 0, 0, 0, 9, 9, 0, 9, 0, 1, 1, 0,  0, 0, 0, 0, 2, 2, 2, 1}); // M=00 preferred
        vecs.push_back('{0, 0, 0, 0, 9, 9, 0, 9, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 1}); // no RegWrite
        s = vecs[0];
        drive(s);
        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end
        s = '{default: '0};
        s.pcs = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(s);
        end
        @(negedge clk);
        s.clr = 1'b1;
        drive(s);
        #1;
        chk("sat.flush_cnt", 16'(hz_if.flush_cnt), 16'd15);
        chk("sat.stall_cnt", 16'(hz_if.stall_cnt), 16'd2);
        chk("sat.FlushD", 16'(hz_if.FlushD), 16'd1);
        @(negedge clk);
        s = '{default: '0};
        drive(s);
        #1;
        chk("clr.flush_cnt", 16'(hz_if.flush_cnt), 16'd0);
        chk("clr.stall_cnt", 16'(hz_if.stall_cnt), 16'd0);
        @(negedge clk);
        s.pcs = 2'b01;
        drive(s);
        @(negedge clk);
        s.pcs = 2'b00;
        drive(s);
        #1;
        chk("inc.flush_cnt", 16'(hz_if.flush_cnt), 16'd1);
        @(negedge clk);
        s = '{default: '0};
        s.rst = 1'b1; s.rsrce = 2'b01; s.rde = 5'd3; s.rs1 = 5'd3;
        s.rdm = 5'd5; s.rwm = 1'b1; s.rs1e = 5'd5; s.rww = 1'b1;
        drive(s);
        #1;
        chk("rst.StallF", 16'(hz_if.StallF), 16'd0);
        chk("rst.StallD", 16'(hz_if.StallD), 16'd0);
        chk("rst.FlushD", 16'(hz_if.FlushD), 16'd1);
        chk("rst.FlushE", 16'(hz_if.FlushE), 16'd1);
        chk("rst.ForwardAE", 16'(hz_if.ForwardAE), 16'd0);
        @(negedge clk);
        #1;
        chk("rst.flush_cnt", 16'(hz_if.flush_cnt), 16'd0);
        chk("rst.stall_cnt", 16'(hz_if.stall_cnt), 16'd0);
        @(negedge clk);
        s.rst = 1'b0;
        drive(s);
        #1;
        chk("post.ForwardAE", 16'(hz_if.ForwardAE), 16'd2);
        chk("post.StallF", 16'(hz_if.StallF), 16'd1);
        chk("post.FlushD", 16'(hz_if.FlushD), 16'd0);
        @(negedge clk);
        #1;
        chk("post.stall_cnt", 16'(hz_if.stall_cnt), 16'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
